// File: rtl/control_seq.sv
// Registered control sequencer for the SPORK datapath: accepts one instruction per handshake,
// decodes it into a registered control bundle and sequences load stalls, branch flushes and halt.
module control_seq #(
  parameter int unsigned INSTR_W    = 9,
  parameter int unsigned OPC_W      = 4,
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned BR_BUBBLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               INSTR_VALID,
  input  logic [INSTR_W-1:0] INSTRUCTION,
  output logic               INSTR_READY,
  input  logic               BRANCH_TAKEN,
  output logic               CTRL_VALID,
  output logic [3:0]         ALU_OP,
  output logic [REG_AW-1:0]  REG_DST,
  output logic [REG_AW-1:0]  SOURCE_REG_A,
  output logic [REG_AW-1:0]  SOURCE_REG_B,
  output logic [REG_AW-1:0]  SOURCE_REG_C,
  output logic               REG_WRITE,
  output logic               REG_READ,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic               MEM_TO_REG,
  output logic               OV_WRITE,
  output logic               BRANCH,
  output logic               HALT,
  output logic               FLUSH,
  output logic               STALL,
  output logic               HALTED,
  output logic [CNT_W-1:0]   INSTR_COUNT
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRun     = 3'd1;
  localparam logic [2:0] StMemWait = 3'd2;
  localparam logic [2:0] StBrWait  = 3'd3;
  localparam logic [2:0] StFlush   = 3'd4;
  localparam logic [2:0] StHalted  = 3'd5;

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluSll = 4'd2;
  localparam logic [3:0] AluSrl = 4'd3;
  localparam logic [3:0] AluSra = 4'd4;
  localparam logic [3:0] AluSeq = 4'd5;
  localparam logic [3:0] AluSqb = 4'd6;
  localparam logic [3:0] AluScp = 4'd7;
  localparam logic [3:0] AluRlz = 4'd8;
  localparam logic [3:0] AluSrg = 4'd9;
  localparam logic [3:0] AluSlg = 4'd10;
  localparam logic [3:0] AluSro = 4'd11;
  localparam logic [3:0] AluSlo = 4'd12;

  // Strobe vector bit order: {reg_write, reg_read, mem_read, mem_write, mem_to_reg, ov_write,
  // branch, halt}
  localparam logic [7:0] SbRw  = 8'b1000_0000;
  localparam logic [7:0] SbRr  = 8'b0100_0000;
  localparam logic [7:0] SbMr  = 8'b0010_0000;
  localparam logic [7:0] SbMw  = 8'b0001_0000;
  localparam logic [7:0] SbM2r = 8'b0000_1000;
  localparam logic [7:0] SbOv  = 8'b0000_0100;
  localparam logic [7:0] SbBr  = 8'b0000_0010;
  localparam logic [7:0] SbHt  = 8'b0000_0001;

  logic [2:0]        state_q, state_d;
  logic [3:0]        mem_cnt_q, mem_cnt_d;
  logic [2:0]        fl_cnt_q, fl_cnt_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [REG_AW-1:0] dst_q, dst_d, src_a_q, src_a_d, src_b_q, src_b_d, src_c_q, src_c_d;
  logic [7:0]        strobe_q, strobe_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [OPC_W-1:0]  opc;
  logic [3:0]        opc_lo;
  logic              opc_wide;
  logic [REG_AW-1:0] fld;
  logic              lb;
  logic              accept;

  logic [3:0]        dec_alu;
  logic [REG_AW-1:0] dec_dst, dec_a, dec_b, dec_c;
  logic [7:0]        dec_strobe;
  logic [2:0]        dec_next;

  assign opc    = INSTRUCTION[INSTR_W-1 -: OPC_W];
  assign opc_lo = opc[3:0];
  assign fld    = INSTRUCTION[REG_AW:1];
  assign lb     = INSTRUCTION[0];

  // Opcodes beyond the 16 defined ones decode as a NOP.
  generate
    if (OPC_W > 4) begin : g_wide_opc
      assign opc_wide = |opc[OPC_W-1:4];
    end else begin : g_narrow_opc
      assign opc_wide = 1'b0;
    end
  endgenerate

  assign INSTR_READY = (state_q == StRun);
  assign accept      = INSTR_VALID & INSTR_READY;

  always_comb begin
    dec_alu    = AluAdd;
    dec_dst    = '0;
    dec_a      = '0;
    dec_b      = '0;
    dec_c      = '0;
    dec_strobe = '0;
    dec_next   = StRun;
    if (!opc_wide) begin
      unique case (opc_lo)
        4'd0: begin
          dec_strobe = SbHt;
          dec_next   = StHalted;
        end
        4'd1, 4'd2: begin
          dec_alu    = (opc_lo == 4'd2) ? AluSll : (lb ? AluSra : AluSrl);
          dec_dst    = fld;
          dec_a      = fld;
          dec_strobe = SbRr | SbRw | SbM2r | SbOv;
        end
        4'd3: begin
          dec_dst    = lb ? '0 : fld;
          dec_a      = lb ? fld : '0;
          dec_strobe = SbRr | SbRw | SbOv;
        end
        4'd4, 4'd5, 4'd6: begin
          dec_alu    = AluSub;
          dec_dst    = (opc_lo == 4'd4) ? REG_AW'(13) : REG_AW'(12);
          dec_a      = fld;
          dec_b      = (opc_lo == 4'd4) ? REG_AW'(14) : REG_AW'(1);
          dec_strobe = SbBr | SbRr | SbOv;
          dec_next   = StBrWait;
        end
        4'd7: begin
          dec_dst    = REG_AW'(2);
          dec_a      = fld;
          dec_strobe = SbM2r | SbOv | (lb ? (SbMw | SbRr) : (SbMr | SbRw));
          dec_next   = lb ? StRun : StMemWait;
        end
        4'd8: begin
          dec_strobe = SbRw | SbM2r | SbOv;
        end
        4'd9: begin
          dec_alu    = lb ? AluSub : AluAdd;
          dec_dst    = REG_AW'(3);
          dec_a      = fld;
          dec_strobe = SbRr | SbRw | SbM2r | SbOv;
        end
        4'd10: begin
          dec_alu    = AluSeq;
          dec_dst    = REG_AW'(5);
          dec_a      = fld;
          dec_b      = REG_AW'(4);
          dec_c      = REG_AW'(5);
          dec_strobe = SbRr | SbRw | SbOv;
        end
        4'd11: begin
          dec_alu    = AluSqb;
          dec_dst    = REG_AW'(5);
          dec_a      = REG_AW'(4);
          dec_b      = REG_AW'(7);
          dec_c      = REG_AW'(8);
          dec_strobe = SbRr | SbRw | SbOv;
        end
        4'd12: begin
          dec_alu    = AluScp;
          dec_dst    = REG_AW'(5);
          dec_a      = REG_AW'(9);
          dec_b      = REG_AW'(4);
          dec_c      = REG_AW'(5);
          dec_strobe = SbRr | SbRw | SbOv;
        end
        4'd13: begin
          dec_alu    = AluRlz;
          dec_dst    = REG_AW'(9);
          dec_a      = REG_AW'(9);
          dec_strobe = SbRr | SbRw | SbOv;
        end
        4'd14, 4'd15: begin
          if (opc_lo == 4'd14) dec_alu = lb ? AluSlg : AluSrg;
          else                 dec_alu = lb ? AluSlo : AluSro;
          dec_dst    = fld;
          dec_a      = fld;
          dec_strobe = SbRr | SbRw | SbOv;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_cnt_d = mem_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    count_d   = count_q + CNT_W'(accept);

    // Strobes are only ever high alongside CTRL_VALID; selects hold between bundles.
    ctrl_valid_d = accept;
    strobe_d     = accept ? dec_strobe : '0;
    alu_op_d     = accept ? dec_alu : alu_op_q;
    dst_d        = accept ? dec_dst : dst_q;
    src_a_d      = accept ? dec_a : src_a_q;
    src_b_d      = accept ? dec_b : src_b_q;
    src_c_d      = accept ? dec_c : src_c_q;

    case (state_q)
      StIdle, StHalted: begin
        if (START) state_d = StRun;
      end
      StRun: begin
        if (accept) begin
          state_d   = dec_next;
          mem_cnt_d = 4'(MEM_LAT - 1);
        end
      end
      StMemWait: begin
        if (mem_cnt_q == 4'd0) state_d = StRun;
        else                   mem_cnt_d = mem_cnt_q - 4'd1;
      end
      StBrWait: begin
        if (BRANCH_TAKEN) begin
          state_d  = StFlush;
          fl_cnt_d = 3'(BR_BUBBLES - 1);
        end else begin
          state_d = StRun;
        end
      end
      StFlush: begin
        if (fl_cnt_q == 3'd0) state_d = StRun;
        else                  fl_cnt_d = fl_cnt_q - 3'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      mem_cnt_q    <= '0;
      fl_cnt_q     <= '0;
      ctrl_valid_q <= 1'b0;
      alu_op_q     <= '0;
      dst_q        <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      src_c_q      <= '0;
      strobe_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      mem_cnt_q    <= mem_cnt_d;
      fl_cnt_q     <= fl_cnt_d;
      ctrl_valid_q <= ctrl_valid_d;
      alu_op_q     <= alu_op_d;
      dst_q        <= dst_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      src_c_q      <= src_c_d;
      strobe_q     <= strobe_d;
      count_q      <= count_d;
    end
  end

  assign CTRL_VALID   = ctrl_valid_q;
  assign ALU_OP       = alu_op_q;
  assign REG_DST      = dst_q;
  assign SOURCE_REG_A = src_a_q;
  assign SOURCE_REG_B = src_b_q;
  assign SOURCE_REG_C = src_c_q;
  assign REG_WRITE    = strobe_q[7];
  assign REG_READ     = strobe_q[6];
  assign MEM_READ     = strobe_q[5];
  assign MEM_WRITE    = strobe_q[4];
  assign MEM_TO_REG   = strobe_q[3];
  assign OV_WRITE     = strobe_q[2];
  assign BRANCH       = strobe_q[1];
  assign HALT         = strobe_q[0];
  assign FLUSH        = (state_q == StFlush);
  assign STALL        = (state_q == StMemWait) || (state_q == StFlush);
  assign HALTED       = (state_q == StHalted);
  assign INSTR_COUNT  = count_q;

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: expected bundles are queued at each accept and compared
// when CTRL_VALID appears; accept latencies, stall/flush lengths and reset behaviour are checked.
module tb_control_seq;

  logic       CLK = 1'b0;
  logic       RESET_N, START, INSTR_VALID, BRANCH_TAKEN;
  logic [8:0] INSTRUCTION;
  logic       INSTR_READY, CTRL_VALID;
  logic [3:0] ALU_OP, REG_DST, SOURCE_REG_A, SOURCE_REG_B, SOURCE_REG_C;
  logic       REG_WRITE, REG_READ, MEM_READ, MEM_WRITE, MEM_TO_REG, OV_WRITE, BRANCH, HALT;
  logic       FLUSH, STALL, HALTED;
  logic [2:0] INSTR_COUNT;

  control_seq #(
    .INSTR_W(9), .OPC_W(4), .REG_AW(4), .MEM_LAT(3), .BR_BUBBLES(2), .CNT_W(3)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .INSTR_VALID(INSTR_VALID),
    .INSTRUCTION(INSTRUCTION), .INSTR_READY(INSTR_READY), .BRANCH_TAKEN(BRANCH_TAKEN),
    .CTRL_VALID(CTRL_VALID), .ALU_OP(ALU_OP), .REG_DST(REG_DST), .SOURCE_REG_A(SOURCE_REG_A),
    .SOURCE_REG_B(SOURCE_REG_B), .SOURCE_REG_C(SOURCE_REG_C), .REG_WRITE(REG_WRITE),
    .REG_READ(REG_READ), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_TO_REG(MEM_TO_REG),
    .OV_WRITE(OV_WRITE), .BRANCH(BRANCH), .HALT(HALT), .FLUSH(FLUSH), .STALL(STALL),
    .HALTED(HALTED), .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [30:0] sb_q[$];
  logic [2:0]  exp_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] enc(input int opc, input int fld, input int l);
    logic [8:0] r;
    r = {4'(opc), 4'(fld), 1'(l)};
    return r;
  endfunction

  // Reference decode: {alu, dst, a, b, c, rw, rr, mr, mw, m2r, ov, br, ht}
  function automatic logic [27:0] model(input logic [8:0] ins);
    logic [3:0] op, f, alu, d, a, b, c;
    logic       l;
    logic [7:0] s;
    op = ins[8:5]; f = ins[4:1]; l = ins[0];
    alu = 0; d = 0; a = 0; b = 0; c = 0; s = 0;
    case (op)
      0:  s = 8'b0000_0001;
      1:  begin alu = l ? 4 : 3; d = f; a = f; s = 8'b1100_1100; end
      2:  begin alu = 2; d = f; a = f; s = 8'b1100_1100; end
      3:  begin s = 8'b1100_0100; if (l) a = f; else d = f; end
      4:  begin alu = 1; d = 13; a = f; b = 14; s = 8'b0100_0110; end
      5, 6: begin alu = 1; d = 12; a = f; b = 1; s = 8'b0100_0110; end
      7:  begin d = 2; a = f; s = l ? 8'b0101_1100 : 8'b1010_1100; end
      8:  s = 8'b1000_1100;
      9:  begin alu = l ? 1 : 0; d = 3; a = f; s = 8'b1100_1100; end
      10: begin alu = 5; d = 5; a = f; b = 4; c = 5; s = 8'b1100_0100; end
      11: begin alu = 6; d = 5; a = 4; b = 7; c = 8; s = 8'b1100_0100; end
      12: begin alu = 7; d = 5; a = 9; b = 4; c = 5; s = 8'b1100_0100; end
      13: begin alu = 8; d = 9; a = 9; s = 8'b1100_0100; end
      14: begin alu = l ? 10 : 9; d = f; a = f; s = 8'b1100_0100; end
      default: begin alu = l ? 12 : 11; d = f; a = f; s = 8'b1100_0100; end
    endcase
    return {alu, d, a, b, c, s};
  endfunction

  // Cycles the next instruction must wait after this one (branches not taken).
  function automatic int exp_wait(input logic [8:0] prev);
    if (prev[8:5] == 4'd7 && !prev[0]) return 3;
    if (prev[8:5] >= 4'd4 && prev[8:5] <= 4'd6) return 1;
    return 0;
  endfunction

  task automatic send(input logic [8:0] ins, output int waits, output int stalls,
                      output int flushes);
    @(negedge CLK);
    INSTR_VALID = 1'b1;
    INSTRUCTION = ins;
    waits = 0; stalls = 0; flushes = 0;
    while (!INSTR_READY && waits < 40) begin
      stalls  += int'(STALL);
      flushes += int'(FLUSH);
      waits++;
      @(negedge CLK);
    end
    if (!INSTR_READY) begin
      check_eq("accept_timeout", 32'(INSTR_READY), 1);
      return;
    end
    exp_cnt++;
    sb_q.push_back({exp_cnt, model(ins)});
    @(posedge CLK);
  endtask

  task automatic idle();
    @(negedge CLK);
    INSTR_VALID = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check_eq("start_ready", 32'(INSTR_READY), 1);
  endtask

  // Scoreboard monitor, sampling 1 time unit after each rising edge.
  always @(posedge CLK) begin
    logic [30:0] e;
    #1;
    if (CTRL_VALID) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_valid", 32'(CTRL_VALID), 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("bundle", {ALU_OP, REG_DST, SOURCE_REG_A, SOURCE_REG_B, SOURCE_REG_C, REG_WRITE,
                            REG_READ, MEM_READ, MEM_WRITE, MEM_TO_REG, OV_WRITE, BRANCH, HALT},
                 32'(e[27:0]));
        check_eq("count", 32'(INSTR_COUNT), 32'(e[30:28]));
      end
    end else begin
      check_eq("bubble_strobes", {REG_WRITE, REG_READ, MEM_READ, MEM_WRITE, MEM_TO_REG,
                                  OV_WRITE, BRANCH, HALT}, 0);
    end
  end

  initial begin
    int          w, s, f, hc;
    logic [8:0]  prev;
    logic [8:0]  tbl[17];
    RESET_N = 1'b0; START = 1'b0; INSTR_VALID = 1'b0; INSTRUCTION = '0; BRANCH_TAKEN = 1'b0;
    exp_cnt = '0;
    #12;
    check_eq("rst_ready", 32'(INSTR_READY), 0);
    check_eq("rst_outs", {CTRL_VALID, ALU_OP, REG_DST, SOURCE_REG_A, SOURCE_REG_B,
                          SOURCE_REG_C, FLUSH, STALL, HALTED}, 0);
    check_eq("rst_count", 32'(INSTR_COUNT), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("idle_not_ready", 32'(INSTR_READY), 0);
    start_pulse();

    send(enc(9, 0, 0), w, s, f);
    check_eq("add_wait", w, 0);
    send(enc(7, 3, 0), w, s, f);
    check_eq("load_wait", w, 0);
    send(enc(9, 1, 1), w, s, f);
    check_eq("after_load_wait", w, 3);
    check_eq("after_load_stall", s, 3);
    check_eq("after_load_flush", f, 0);

    BRANCH_TAKEN = 1'b1;
    send(enc(4, 2, 0), w, s, f);
    check_eq("beq_wait", w, 0);
    send(enc(3, 6, 0), w, s, f);
    check_eq("taken_wait", w, 3);
    check_eq("taken_stall", s, 2);
    check_eq("taken_flush", f, 2);
    BRANCH_TAKEN = 1'b0;
    send(enc(4, 2, 0), w, s, f);
    send(enc(3, 6, 1), w, s, f);
    check_eq("ntaken_wait", w, 1);
    check_eq("ntaken_flush", f, 0);

    tbl = '{enc(7, 4, 1), enc(1, 3, 0), enc(1, 3, 1), enc(2, 5, 0), enc(8, 7, 0),
            enc(9, 2, 1), enc(10, 3, 0), enc(11, 0, 0), enc(12, 0, 1), enc(13, 0, 0),
            enc(14, 6, 0), enc(14, 6, 1), enc(15, 2, 0), enc(15, 2, 1), enc(5, 9, 0),
            enc(6, 10, 1), enc(3, 1, 1)};
    prev = enc(3, 6, 1);
    foreach (tbl[i]) begin
      send(tbl[i], w, s, f);
      check_eq("table_wait", w, exp_wait(prev));
      prev = tbl[i];
    end

    send(enc(0, 0, 0), w, s, f);
    idle();
    hc = 0;
    repeat (10) begin
      if (HALTED && !INSTR_READY) hc++;
      @(negedge CLK);
    end
    check_eq("halted_cycles", hc, 10);
    start_pulse();
    check_eq("resume_halted", 32'(HALTED), 0);
    send(enc(9, 2, 0), w, s, f);
    check_eq("resume_wait", w, 0);

    send(enc(7, 5, 0), w, s, f);
    idle();
    check_eq("memwait_stall", 32'(STALL), 1);
    #1 RESET_N = 1'b0;
    #1;
    exp_cnt = '0;
    check_eq("arst_ready", 32'(INSTR_READY), 0);
    check_eq("arst_outs", {CTRL_VALID, FLUSH, STALL, HALTED, REG_WRITE, MEM_READ}, 0);
    check_eq("arst_count", 32'(INSTR_COUNT), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
    check_eq("post_rst_idle", {INSTR_READY, STALL}, 0);
    start_pulse();

    for (int i = 0; i < 9; i++) begin
      send(enc(3, i, 0), w, s, f);
    end
    idle();
    repeat (3) @(negedge CLK);
    check_eq("wrap_count", 32'(INSTR_COUNT), 1);
    check_eq("sb_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
